systolic_result_drain: RTL and testbench
========================================

// Module: systolic_result_drain
// PURPOSE
//  Output-side reader for one row of float PEs. After the row's done flag, waits for
//  the PE accumulate pipelines to settle, snapshots every PE's accumulated result,
//  then streams the results out one word per beat on a valid/ready interface.
//  Sits between the systolic array's out_c buses and the result write-back path.
// PARAMETERS
//  WIDTH          16  result word width (fp16: 1/5/10)
//  NUM_PE         4   PEs in the row; number of words per drain burst (>=1)
//  SETTLE_CYCLES  6   cycles from done flag to snapshot (>=1); covers PE drain + adder pipe
//  IDX_W          2   index width, $clog2(NUM_PE) (min 1)
// PORTS
//  clk            in   1               clock, all logic on posedge
//  rst_n          in   1               synchronous reset, active low
//  in_done_flag   in   1               same done flag driven into the PE row
//  in_c           in   NUM_PE*WIDTH    PE k accumulated result at in_c[k*WIDTH +: WIDTH]
//  out_ready      in   1               downstream accepts the current beat
//  out_valid      out  1               out_data/out_idx/out_last valid
//  out_data       out  WIDTH           result word of PE out_idx
//  out_idx        out  IDX_W           PE index of current word
//  out_last       out  1               current beat is PE NUM_PE-1
//  capture_pulse  out  1               1-cycle pulse on the cycle after snapshot
//  busy           out  1               state != IDLE
//  overrun        out  1               1-cycle pulse: done flag seen while busy
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, cnt=0, idx=0, buffer=0; all outputs 0.
//   Reset has priority over everything, incl. mid-SETTLE or mid-STREAM; burst is lost.
//  All outputs registered or decoded from registered state only; no comb in->out path.
//  States:
//   IDLE   : in_done_flag=1 -> SETTLE, cnt<=SETTLE_CYCLES-1. Else stay.
//   SETTLE : cnt!=0 -> cnt<=cnt-1. cnt==0 -> buffer[k]<=in_c[k] for all k, idx<=0,
//            capture_pulse<=1, -> STREAM.
//   STREAM : out_valid=1, out_data=buffer[idx], out_idx=idx, out_last=(idx==NUM_PE-1).
//            Beat accepted when out_valid&&out_ready: idx==NUM_PE-1 -> IDLE, idx<=0;
//            else idx<=idx+1. No accept -> data/idx/last held stable.
//  Latency: done sampled at edge E0 -> snapshot at edge E0+SETTLE_CYCLES; out_valid
//   high from that edge; min burst = NUM_PE cycles with out_ready tied high.
//  in_c sampled only at the snapshot edge; later changes do not affect streamed data.
//  in_done_flag while busy (SETTLE or STREAM): ignored, overrun<=1 for one cycle; no
//   restart, no counter reload. Done held high across several cycles in IDLE starts one
//   burst; remaining high cycles count as overrun.
//  Done in the same cycle as the final accepted beat: final beat completes, return to
//   IDLE, done is flagged overrun (not queued).
//  NUM_PE==1: each burst is a single beat with out_last=1, idx stays 0.
//  busy = (state!=IDLE), registered with state.
//  Words are passed through bit-exact; no float arithmetic in this block.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles mid-STREAM -> out_valid=0, busy=0, idx=0 the next cycle.
//  2 Basic burst, NUM_PE=4, SETTLE=6, ready=1: in_c={16'h4400,16'h4200,16'h4000,16'h3C00},
//    done at E0 -> out_valid rises at E6; beats 3C00,4000,4200,4400 idx 0..3, last on idx 3.
//  3 Backpressure: ready=0 for 3 cycles on idx 1 -> out_data=16'h4000, idx=1 held; resumes
//    in order, exactly 4 accepted beats total.
//  4 Snapshot isolation: change in_c to 16'hFFFF per word after snapshot edge -> streamed
//    words still the pre-change values.
//  5 Overrun: second done pulse during SETTLE and during STREAM -> overrun=1 one cycle each,
//    burst timing/data unchanged, single burst only.
//  6 Back-to-back: done in same cycle as last accepted beat -> overrun=1, IDLE next; a new
//    done one cycle later starts a full new burst.

Source files
------------

// File: rtl/systolic_result_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_result_drain_if
//  Description : Valid/ready result stream from the row drain to the
//                write-back path (one result word per beat).
//  Revision    : 1.0 - initial release
// ============================================================================
interface systolic_result_drain_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  // Drain side: produces the beat, observes downstream acceptance
  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  // Write-back side: consumes the beat, drives acceptance
  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_result_drain
//  Description : After the PE row's done flag, waits for the accumulate
//                pipelines to settle, snapshots every PE result and streams
//                the words out one per beat on a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_result_drain #(
  parameter int WIDTH         = 16,
  parameter int NUM_PE        = 4,
  parameter int SETTLE_CYCLES = 6,
  parameter int IDX_W         = 2
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    in_done_flag,
  input  wire logic [NUM_PE*WIDTH-1:0] in_c,
  systolic_result_drain_if.master      out_bus,
  output logic                         capture_pulse,
  output logic                         busy,
  output logic                         overrun
);

  localparam int                 c_CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NUM_PE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               r_capture;
  logic               w_capture_nxt;
  logic               r_overrun;
  logic               w_overrun_nxt;
  logic               r_busy;
  logic               w_snap;
  logic               w_streaming;
  logic               w_at_last;
  logic [WIDTH-1:0]   r_buf [NUM_PE];

  assign w_streaming = (r_state == S_STREAM);
  assign w_at_last   = (r_idx == c_LAST_IDX);

  // Next-state, counter, index and pulse decode from registered state
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_capture_nxt = 1'b0;
    w_overrun_nxt = 1'b0;
    w_snap        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_done_flag) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = c_CNT_LOAD;
        end
      end
      S_SETTLE: begin
        // A done flag while a burst is in flight is reported, never queued
        w_overrun_nxt = in_done_flag;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_snap        = 1'b1;
          w_idx_nxt     = '0;
          w_capture_nxt = 1'b1;
          w_state_nxt   = S_STREAM;
        end
      end
      S_STREAM: begin
        w_overrun_nxt = in_done_flag;
        if (out_bus.out_ready) begin
          if (w_at_last) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register plus control counters and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_capture <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_capture <= w_capture_nxt;
      r_overrun <= w_overrun_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  generate
    for (genvar k = 0; k < NUM_PE; k++) begin : g_buf
      // Snapshot PE k's result once the pipelines have settled
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_buf[k] <= '0;
        end else if (w_snap) begin
          r_buf[k] <= in_c[k*WIDTH +: WIDTH];
        end
      end
    end
  endgenerate

  // Stream outputs are decoded from registered state only; idle beats read as zero
  assign out_bus.out_valid = w_streaming;
  assign out_bus.out_data  = w_streaming ? r_buf[r_idx] : '0;
  assign out_bus.out_idx   = r_idx;
  assign out_bus.out_last  = w_streaming && w_at_last;
  assign capture_pulse     = r_capture;
  assign busy              = r_busy;
  assign overrun           = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_result_drain
//  Description : Scoreboard bench for systolic_result_drain: expected beats
//                are queued by the stimulus, a monitor pops and compares
//                every accepted beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_result_drain;

  localparam int c_WIDTH  = 16;
  localparam int c_NUM_PE = 4;
  localparam int c_IDX_W  = 2;

  typedef struct packed {
    logic [c_WIDTH-1:0] data;
    logic [c_IDX_W-1:0] idx;
    logic               last;
  } beat_t;

  logic                        clk;
  logic                        rst_n;
  logic                        in_done_flag;
  logic [c_NUM_PE*c_WIDTH-1:0] in_c;
  logic                        capture_pulse;
  logic                        busy;
  logic                        overrun;

  int    checks;
  int    errors;
  int    beats;
  beat_t exp_q[$];

  systolic_result_drain_if #(.WIDTH(c_WIDTH), .IDX_W(c_IDX_W)) bus ();

  systolic_result_drain #(
    .WIDTH         (c_WIDTH),
    .NUM_PE        (c_NUM_PE),
    .SETTLE_CYCLES (6),
    .IDX_W         (c_IDX_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_done_flag  (in_done_flag),
    .in_c          (in_c),
    .out_bus       (bus.master),
    .capture_pulse (capture_pulse),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic [c_NUM_PE*c_WIDTH-1:0] c);
    beat_t b;
    for (int k = 0; k < c_NUM_PE; k++) begin
      b.data = c[k*c_WIDTH +: c_WIDTH];
      b.idx  = c_IDX_W'(k);
      b.last = (k == c_NUM_PE - 1);
      exp_q.push_back(b);
    end
  endtask

  // One-cycle done pulse; returns just after edge E0
  task automatic fire_done();
    in_done_flag = 1'b1;
    tick();
    in_done_flag = 1'b0;
  endtask

  // From just after E0: valid must stay low through E5 and rise at E6
  task automatic wait_rise(input string name);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check({name, "_settle_valid"}, bus.out_valid, 1'b0);
    end
    tick();
    check({name, "_rise_valid"}, bus.out_valid, 1'b1);
    check({name, "_capture"}, capture_pulse, 1'b1);
    check({name, "_first_idx"}, bus.out_idx, 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, busy, 1'b0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every accepted beat must match the head of the queue
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", bus.out_data, e.data);
        check("beat_idx", bus.out_idx, e.idx);
        check("beat_last", bus.out_last, e.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    logic [c_NUM_PE*c_WIDTH-1:0] va, vb;
    checks        = 0;
    errors        = 0;
    beats         = 0;
    rst_n         = 1'b0;
    in_done_flag  = 1'b0;
    in_c          = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_idx", bus.out_idx, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_last", bus.out_last, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_capture", capture_pulse, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic burst with ready tied high
    in_c          = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    bus.out_ready = 1'b1;
    push_burst(in_c);
    b0 = beats;
    fire_done();
    check("basic_busy", busy, 1'b1);
    wait_rise("basic");
    check("basic_first_data", bus.out_data, 16'h3C00);
    wait_idle("basic");
    check("basic_beats", beats - b0, 4);

    // Backpressure on idx 1
    push_burst(in_c);
    b0 = beats;
    fire_done();
    wait_rise("bp");
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_idx", bus.out_idx, 1);
      check("bp_hold_data", bus.out_data, 16'h4000);
      check("bp_hold_valid", bus.out_valid, 1'b1);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_idle("bp");
    check("bp_beats", beats - b0, 4);

    // Snapshot isolation
    va   = {16'h4800, 16'h4600, 16'h4500, 16'h3E00};
    in_c = va;
    push_burst(va);
    fire_done();
    wait_rise("snap");
    in_c = {4{16'hFFFF}};
    wait_idle("snap");

    // Overrun during SETTLE and during STREAM
    vb   = {16'hC000, 16'hBC00, 16'h0001, 16'h7BFF};
    in_c = vb;
    push_burst(vb);
    b0 = beats;
    fire_done();
    in_done_flag = 1'b1;
    tick();
    in_done_flag = 1'b0;
    check("ovr_settle_pulse", overrun, 1'b1);
    check("ovr_settle_busy", busy, 1'b1);
    tick();
    check("ovr_settle_clear", overrun, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ovr_settle_valid", bus.out_valid, 1'b0);
    end
    tick();
    check("ovr_rise_valid", bus.out_valid, 1'b1);
    check("ovr_rise_data", bus.out_data, 16'h7BFF);
    bus.out_ready = 1'b0;
    in_done_flag  = 1'b1;
    tick();
    in_done_flag = 1'b0;
    check("ovr_stream_pulse", overrun, 1'b1);
    check("ovr_stream_idx", bus.out_idx, 0);
    bus.out_ready = 1'b1;
    tick();
    check("ovr_stream_clear", overrun, 1'b0);
    wait_idle("ovr");
    for (int k = 0; k < 8; k++) begin
      tick();
      check("ovr_no_restart", busy, 1'b0);
    end
    check("ovr_beats", beats - b0, 4);

    // Done on the final accepted beat, then a fresh burst
    in_c = va;
    push_burst(va);
    fire_done();
    wait_rise("b2b");
    tick();
    tick();
    tick();
    check("b2b_last_idx", bus.out_idx, 3);
    check("b2b_last_flag", bus.out_last, 1'b1);
    in_done_flag = 1'b1;
    in_c         = vb;
    tick();
    in_done_flag = 1'b0;
    check("b2b_overrun", overrun, 1'b1);
    check("b2b_idle_busy", busy, 1'b0);
    check("b2b_idle_valid", bus.out_valid, 1'b0);
    tick();
    check("b2b_gap_busy", busy, 1'b0);
    push_burst(vb);
    b0 = beats;
    fire_done();
    wait_rise("b2b_new");
    wait_idle("b2b_new");
    check("b2b_new_beats", beats - b0, 4);

    // Reset mid-STREAM drops the burst
    bus.out_ready = 1'b0;
    in_c          = va;
    fire_done();
    wait_rise("rstm");
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    check("rstm_valid", bus.out_valid, 1'b0);
    check("rstm_busy", busy, 1'b0);
    check("rstm_idx", bus.out_idx, 0);
    check("rstm_data", bus.out_data, 0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rstm_no_resume", bus.out_valid, 1'b0);
    end
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
